pos_read_scheduler: RTL and testbench
=====================================

Name: pos_read_scheduler

Overview:
- Sequences the position read datapath for one force-evaluation iteration.
- Drives phase, ref_id, particle_id, reading_particle_num and pause_reading into pos_data_preprocessor and the position caches.
- Reads the home-cell particle count first. Then, for every home reference particle, sweeps the neighbour particle IDs in phase 0, then in phase 1.
- Stalls on filter back-pressure, drains the pipeline after the last sweep, and signals done.

Parameters:
- PARTICLE_ID_WIDTH, 7: width of particle IDs and counts.
- NUM_FILTER, 7: number of filter lanes giving back-pressure.
- COUNT_LATENCY, 2: cycles from the reading_particle_num pulse until home_particle_count is valid.
- DRAIN_CYCLES, 16: cycles waited after the last issued read before done.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins an iteration; ignored unless in IDLE.
- home_particle_count, input, PARTICLE_ID_WIDTH: home-cell count from the preprocessor.
- nb_max_count, input, PARTICLE_ID_WIDTH: largest particle count among neighbour cells; sets the sweep length.
- filter_almost_full, input, NUM_FILTER: per-lane back-pressure.
- phase, output, 1: global phase; 0 selects the first cell half, 1 the second.
- reading_particle_num, output, 1: high while the count word (address 0) is being read.
- pause_reading, output, 1: the current issue slot is a stall repeat.
- ref_id, output, PARTICLE_ID_WIDTH: home reference particle index, 1-based.
- particle_id, output, PARTICLE_ID_WIDTH: neighbour read address, 1-based; 0 means the count word.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse at the end of an iteration.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high. All outputs are registered.
- Reset, including mid-operation: state goes to IDLE and every output goes to 0. No done pulse is produced for an aborted iteration.
- IDLE: start=1 -> RD_NUM.
- RD_NUM, 1 cycle:
  - Outputs: reading_particle_num=1, phase=0, particle_id=0, ref_id=0.
  - Next state: WAIT_NUM.
- WAIT_NUM:
  - Waits COUNT_LATENCY cycles, counted by a down-counter.
  - Then samples home_particle_count and nb_max_count into internal registers.
  - Either sampled value == 0 -> DRAIN. Otherwise ref_id<=1, particle_id<=1, phase<=0 -> SWEEP.
- SWEEP, one read issued per cycle:
  - particle_id increments from 1 to nb_max_count_r.
  - At nb_max_count_r with phase=0: phase<=1, particle_id<=1.
  - At nb_max_count_r with phase=1: if ref_id == home_count_r -> DRAIN. Otherwise ref_id+1, phase<=0, particle_id<=1.
  - No bubble cycle between sweeps or at a phase change.
- Back-pressure:
  - If |filter_almost_full is sampled at a clock edge in SWEEP, all counters and the phase hold, and pause_reading<=1.
  - The same ref_id/particle_id/phase is presented again with pause high.
  - pause_reading clears on the first edge where back-pressure is low. That cycle presents the next address.
  - Back-pressure is ignored outside SWEEP.
- DRAIN:
  - Waits DRAIN_CYCLES; outputs hold their last values, pause_reading=1.
  - Then done<=1 for one cycle and state -> IDLE.
  - On entering IDLE, phase, ref_id and particle_id go to 0.
- Arithmetic:
  - Counters are PARTICLE_ID_WIDTH wide. Compares use the registered counts only, so input changes after sampling are ignored.
  - A count at its maximum value (127) must not wrap. The terminal compare uses equality before the increment.
- Simultaneous events:
  - start during busy is ignored.
  - start in the same cycle as rst: reset wins.
  - A stall in the last SWEEP cycle delays entry to DRAIN.
- Issued reads per iteration: home_count_r × 2 × nb_max_count_r, not counting stall repeats.

Decomposition:
- Shared package md_ctrl_pkg holds:
  - a state enum typedef with members IDLE, RD_NUM, WAIT_NUM, SWEEP, DRAIN;
  - a constant COUNT_WORD_ADDR = 0.
- One sub-module, sweep_counter: the particle_id/phase/ref_id nested counter with hold enable and terminal flags. It is instantiated once; the FSM stays in the top level.

Test Plan:
- Reset, then start with home=2 and nb_max=3:
  - RD_NUM holds particle_id=0 with reading_particle_num=1.
  - Then 12 issue cycles in order (ref,phase,pid) = (1,0,1..3), (1,1,1..3), (2,0,1..3), (2,1,1..3).
  - done pulses exactly DRAIN_CYCLES+1 cycles after the last issue.
- home=0: no SWEEP cycles, ref_id stays 0, done pulses after DRAIN.
- home=1, nb_max=4, filter_almost_full[3] high for 3 cycles at pid=2: pid=2 repeats with pause_reading=1 for 3 cycles, then pid=3 follows. Total issues = 8.
- rst asserted mid-SWEEP at ref=1, pid=2: the next cycle shows all outputs 0 and busy=0, and no done pulse. A following start runs a full clean iteration.
- start pulsed while busy, and start together with rst: both ignored; the iteration count and timing are unchanged.
- home=127, nb_max=127: ref_id reaches 127 with no wrap, and DRAIN is entered after 32258 issues.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// Shared control definitions for the force-evaluation position read path.
// Holds the scheduler state encoding and the address of the cell count word.
package md_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_NUM   = 3'd1,
        WAIT_NUM = 3'd2,
        SWEEP    = 3'd3,
        DRAIN    = 3'd4
    } state_e;

    localparam int COUNT_WORD_ADDR = 0;

endpackage

// File: rtl/sweep_counter.sv
// Nested particle_id / phase / ref_id counter for the neighbour sweep.
// The terminal flag is computed before any increment, so maximum counts never wrap.
module sweep_counter
    import md_ctrl_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         init,
    input  logic                         advance,
    input  logic [PARTICLE_ID_WIDTH-1:0] home_count,
    input  logic [PARTICLE_ID_WIDTH-1:0] nb_max_count,
    output logic                         phase,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         sweep_last
);

    localparam logic [PARTICLE_ID_WIDTH-1:0] ONE_C  = PARTICLE_ID_WIDTH'(1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] ADDR_C = PARTICLE_ID_WIDTH'(COUNT_WORD_ADDR);

    logic                         phase_r;
    logic [PARTICLE_ID_WIDTH-1:0] ref_r;
    logic [PARTICLE_ID_WIDTH-1:0] pid_r;
    logic                         pid_last_s;

    assign pid_last_s = (pid_r == nb_max_count);
    assign sweep_last = pid_last_s && phase_r && (ref_r == home_count);

    // Counter state: cleared to the count word, primed for the first sweep, or stepped
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= 1'b0;
            ref_r   <= ADDR_C;
            pid_r   <= ADDR_C;
        end else if (clear) begin
            phase_r <= 1'b0;
            ref_r   <= ADDR_C;
            pid_r   <= ADDR_C;
        end else if (init) begin
            phase_r <= 1'b0;
            ref_r   <= ONE_C;
            pid_r   <= ONE_C;
        end else if (advance) begin
            if (pid_last_s) begin
                pid_r <= ONE_C;
                if (!phase_r) begin
                    phase_r <= 1'b1;
                end else begin
                    phase_r <= 1'b0;
                    ref_r   <= ref_r + ONE_C;
                end
            end else begin
                pid_r <= pid_r + ONE_C;
            end
        end
    end

    assign phase       = phase_r;
    assign ref_id      = ref_r;
    assign particle_id = pid_r;

endmodule

// File: rtl/pos_read_scheduler.sv
// Position read scheduler: reads the home count, sweeps neighbour IDs per reference
// particle in two phases, stalls on filter back-pressure, drains, then pulses done.
module pos_read_scheduler
    import md_ctrl_pkg::*;
#(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int COUNT_LATENCY     = 2,
    parameter int DRAIN_CYCLES      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PARTICLE_ID_WIDTH-1:0] home_particle_count,
    input  logic [PARTICLE_ID_WIDTH-1:0] nb_max_count,
    input  logic [NUM_FILTER-1:0]        filter_almost_full,
    output logic                         phase,
    output logic                         reading_particle_num,
    output logic                         pause_reading,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         busy,
    output logic                         done
);

    localparam int WAIT_MAX = (COUNT_LATENCY > DRAIN_CYCLES) ? COUNT_LATENCY : DRAIN_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO_C = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE_C  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] LAT_LOAD_C  = WAIT_W'(COUNT_LATENCY - 1);
    localparam logic [WAIT_W-1:0] DRN_LOAD_C  = WAIT_W'(DRAIN_CYCLES - 1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] CNT_ZERO_C = {PARTICLE_ID_WIDTH{1'b0}};

    state_e                       state_r, state_s;
    logic [WAIT_W-1:0]            wait_cnt_r, wait_cnt_s;
    logic [PARTICLE_ID_WIDTH-1:0] home_count_r, nb_max_r;
    logic                         rpn_r, rpn_s;
    logic                         pause_r, pause_s;
    logic                         busy_r;
    logic                         done_r, done_s;
    logic                         sample_s, clear_s, init_s, adv_s;
    logic                         stall_s, sweep_last_s;

    assign stall_s = |filter_almost_full;

    sweep_counter #(
        .PARTICLE_ID_WIDTH (PARTICLE_ID_WIDTH)
    ) u_sweep_counter (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear_s),
        .init         (init_s),
        .advance      (adv_s),
        .home_count   (home_count_r),
        .nb_max_count (nb_max_r),
        .phase        (phase),
        .ref_id       (ref_id),
        .particle_id  (particle_id),
        .sweep_last   (sweep_last_s)
    );

    // Next-state and next-output decode; outputs are registered one edge later
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        rpn_s      = 1'b0;
        pause_s    = pause_r;
        done_s     = 1'b0;
        sample_s   = 1'b0;
        clear_s    = 1'b0;
        init_s     = 1'b0;
        adv_s      = 1'b0;
        case (state_r)
            IDLE: begin
                pause_s = 1'b0;
                if (start) begin
                    state_s = RD_NUM;
                    rpn_s   = 1'b1;
                    clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_NUM: begin
                state_s    = WAIT_NUM;
                wait_cnt_s = LAT_LOAD_C;
                pause_s    = 1'b0;
            end
            WAIT_NUM: begin
                if (wait_cnt_r == WAIT_ZERO_C) begin
                    sample_s = 1'b1;
                    if ((home_particle_count == CNT_ZERO_C) || (nb_max_count == CNT_ZERO_C)) begin
                        state_s    = DRAIN;
                        wait_cnt_s = DRN_LOAD_C;
                        pause_s    = 1'b1;
                    end else begin
                        state_s = SWEEP;
                        init_s  = 1'b1;
                        pause_s = 1'b0;
                    end
                end else begin
                    wait_cnt_s = wait_cnt_r - WAIT_ONE_C;
                end
            end
            SWEEP: begin
                // A stall repeats the current slot, including the final one
                if (stall_s) begin
                    pause_s = 1'b1;
                end else if (sweep_last_s) begin
                    state_s    = DRAIN;
                    wait_cnt_s = DRN_LOAD_C;
                    pause_s    = 1'b1;
                end else begin
                    adv_s   = 1'b1;
                    pause_s = 1'b0;
                end
            end
            DRAIN: begin
                if (wait_cnt_r == WAIT_ZERO_C) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    clear_s = 1'b1;
                    pause_s = 1'b0;
                end else begin
                    wait_cnt_s = wait_cnt_r - WAIT_ONE_C;
                    pause_s    = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                clear_s = 1'b1;
                pause_s = 1'b0;
            end
        endcase
    end

    // State, counters, sampled counts and registered flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            wait_cnt_r   <= WAIT_ZERO_C;
            home_count_r <= CNT_ZERO_C;
            nb_max_r     <= CNT_ZERO_C;
            rpn_r        <= 1'b0;
            pause_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if (sample_s) begin
                home_count_r <= home_particle_count;
                nb_max_r     <= nb_max_count;
            end
            rpn_r   <= rpn_s;
            pause_r <= pause_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
        end
    end

    assign reading_particle_num = rpn_r;
    assign pause_reading        = pause_r;
    assign busy                 = busy_r;
    assign done                 = done_r;

endmodule

// File: tb/tb_pos_read_scheduler.sv
// Directed bench for pos_read_scheduler: expected issue tuples are queued per
// iteration and popped as the DUT presents non-stalled reads.
module tb_pos_read_scheduler;

    localparam int DRAIN_C = 16;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [6:0] home_particle_count, nb_max_count;
    logic [6:0] filter_almost_full;
    logic       phase, reading_particle_num, pause_reading, busy, done;
    logic [6:0] ref_id, particle_id;

    typedef struct packed {
        logic [6:0] rid;
        logic       ph;
        logic [6:0] pid;
    } issue_t;

    issue_t exp_q[$];
    int     n_assert = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     n_issue, n_pause, gap, max_ref;
    logic   found, saw;

    pos_read_scheduler dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .home_particle_count  (home_particle_count),
        .nb_max_count         (nb_max_count),
        .filter_almost_full   (filter_almost_full),
        .phase                (phase),
        .reading_particle_num (reading_particle_num),
        .pause_reading        (pause_reading),
        .ref_id               (ref_id),
        .particle_id          (particle_id),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_pid"}, 32'(particle_id), 32'd0);
        chk({tag, "_ref"}, 32'(ref_id), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_rpn"}, 32'(reading_particle_num), 32'd0);
        chk({tag, "_pause"}, 32'(pause_reading), 32'd0);
    endtask

    task automatic run_iter(input logic [6:0] h, input logic [6:0] n, input int stall_pid,
                            input int stall_len, input int mid_start_at, input int budget,
                            output int o_issue, output int o_pause, output int o_gap,
                            output int o_max_ref);
        int     last_issue;
        int     stall_left;
        logic   saw_done;
        issue_t e, o, t;
        o_issue = 0; o_pause = 0; o_gap = -1; o_max_ref = 0;
        stall_left = 0; saw_done = 1'b0;
        home_particle_count = h;
        nb_max_count        = n;
        for (int r = 1; r <= int'(h); r++)
            for (int p = 0; p < 2; p++)
                for (int q = 1; q <= int'(n); q++) begin
                    t.rid = 7'(r); t.ph = 1'(p); t.pid = 7'(q);
                    exp_q.push_back(t);
                end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rd_num_flag", 32'(reading_particle_num), 32'd1);
        chk("rd_num_pid", 32'(particle_id), 32'd0);
        chk("rd_num_ref", 32'(ref_id), 32'd0);
        chk("rd_num_busy", 32'(busy), 32'd1);
        last_issue = cyc;
        for (int i = 0; i < budget && !saw_done; i++) begin
            if (i == mid_start_at) start = 1'b1;
            step();
            start = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) filter_almost_full = 7'b0000000;
            end
            if (int'(ref_id) > o_max_ref) o_max_ref = int'(ref_id);
            if (done) begin
                saw_done = 1'b1;
                o_gap    = cyc - last_issue;
            end else if (busy && !pause_reading && !reading_particle_num && particle_id != 7'd0) begin
                o_issue++;
                last_issue = cyc;
                if (exp_q.size() == 0) begin
                    chk("issue_overflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    o = {ref_id, phase, particle_id};
                    chk("issue_seq", 32'(o), 32'(e));
                end
                if (stall_len > 0 && int'(particle_id) == stall_pid && o_pause == 0 && stall_left == 0) begin
                    filter_almost_full = 7'b0001000;
                    stall_left         = stall_len;
                end
            end else if (busy && pause_reading && stall_pid != 0 && int'(particle_id) == stall_pid) begin
                o_pause++;
            end
        end
        chk("done_seen", 32'(saw_done), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        step();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk_idle("post_done");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        home_particle_count = 7'd0; nb_max_count = 7'd0; filter_almost_full = 7'd0;
        step(); step();
        rst = 1'b0;
        step();
        chk_idle("reset");
        chk("reset_done", 32'(done), 32'd0);

        // Basic two-reference sweep
        run_iter(7'd2, 7'd3, 0, 0, -1, 200, n_issue, n_pause, gap, max_ref);
        chk("basic_issues", n_issue, 12);
        chk("basic_gap", gap, DRAIN_C + 1);
        chk("basic_max_ref", max_ref, 2);

        // Empty home cell: straight to drain
        run_iter(7'd0, 7'd5, 0, 0, -1, 200, n_issue, n_pause, gap, max_ref);
        chk("empty_issues", n_issue, 0);
        chk("empty_max_ref", max_ref, 0);
        chk("empty_gap", gap, DRAIN_C + 3);

        // Back-pressure on lane 3 while pid=2 is presented
        run_iter(7'd1, 7'd4, 2, 3, -1, 200, n_issue, n_pause, gap, max_ref);
        chk("stall_issues", n_issue, 8);
        chk("stall_pauses", n_pause, 3);
        chk("stall_gap", gap, DRAIN_C + 1);

        // Reset in the middle of a sweep
        home_particle_count = 7'd2; nb_max_count = 7'd3;
        start = 1'b1; step(); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (busy && !pause_reading && ref_id == 7'd1 && phase == 1'b0 && particle_id == 7'd2)
                found = 1'b1;
        end
        chk("abort_point_found", 32'(found), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk_idle("abort");
        chk("abort_done", 32'(done), 32'd0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) saw = 1'b1;
        end
        chk("abort_quiet", 32'(saw), 32'd0);
        run_iter(7'd2, 7'd3, 0, 0, -1, 200, n_issue, n_pause, gap, max_ref);
        chk("after_abort_issues", n_issue, 12);
        chk("after_abort_gap", gap, DRAIN_C + 1);

        // start while busy is ignored
        run_iter(7'd2, 7'd3, 0, 0, 5, 200, n_issue, n_pause, gap, max_ref);
        chk("busy_start_issues", n_issue, 12);
        chk("busy_start_gap", gap, DRAIN_C + 1);

        // start together with reset is ignored
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        chk_idle("rst_start");
        step();
        chk("rst_start_busy2", 32'(busy), 32'd0);
        chk("rst_start_rpn2", 32'(reading_particle_num), 32'd0);

        // Maximum counts: no wrap of ref_id or particle_id
        run_iter(7'd127, 7'd127, 0, 0, -1, 33000, n_issue, n_pause, gap, max_ref);
        chk("max_issues", n_issue, 32258);
        chk("max_ref", max_ref, 127);
        chk("max_gap", gap, DRAIN_C + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
